mux_8x1_rr: RTL and testbench

MUX_8X1_RR -- requirements
Module: mux_8x1_rr

---
 rtl/mux_8x1_rr.sv | 124 ++++++++++++
 tb/tb_mux_8x1_rr.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_8x1_rr.sv
// 8-channel round-robin gather multiplexer with a registered valid/ready output stage.
// One grant per IDLE->HOLD pass; the scan pointer advances past the winner only when its transfer completes.
module mux_8x1_rr #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  output logic [7:0]     ack,
  output logic [W-1:0]   dout,
  output logic [2:0]     sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     xfer_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]   state_q,     state_d;
  logic [2:0]   ptr_q,       ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   ack_q,       ack_d;
  logic [2:0]   sel_q,       sel_d;
  logic [W-1:0] dout_q,      dout_d;
  logic [7:0]   cnt_q,       cnt_d;

  logic [3:0]   pick_s;
  logic         win_found_s;
  logic [2:0]   win_idx_s;
  logic [W-1:0] win_data_s;

  // Returns {found, index} of the first set request scanning from p upward, wrapping 7 to 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      k = p + 3'(i);
      if (!res[3] && r[k]) begin
        res = {1'b1, k};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration result for the current pointer and request vector.
  always_comb begin
    pick_s      = rr_pick(req, ptr_q);
    win_found_s = pick_s[3];
    win_idx_s   = pick_s[2:0];
    win_data_s  = din[int'(win_idx_s)*W +: W];
  end

  // Next-state logic: grant in IDLE, hold under backpressure, complete on out_ready.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    ack_d       = 8'h00;
    sel_d       = sel_q;
    dout_d      = dout_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          sel_d       = win_idx_s;
          dout_d      = win_data_s;
          out_valid_d = 1'b1;
          ack_d       = 8'h01 << win_idx_s;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // req is deliberately not looked at here, so the completing edge leaves a bubble.
        if (out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = sel_q + 3'd1;
          cnt_d       = cnt_q + 8'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      out_valid_q <= 1'b0;
      ack_q       <= 8'h00;
      sel_q       <= 3'd0;
      dout_q      <= '0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
      sel_q       <= sel_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign dout      = dout_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_8x1_rr.sv
// Directed bench for mux_8x1_rr (W=4): a cycle table plus hand-written multi-cycle sequences.
module tb_mux_8x1_rr;

  localparam int W = 4;
  localparam logic [31:0] DA = 32'h89ABCDEF; // lane k = 15-k
  localparam logic [31:0] DB = 32'h76543210; // lane k = k

  logic           clk;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [7:0]     ack;
  logic [W-1:0]   dout;
  logic [2:0]     sel;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     xfer_cnt;

  int total;
  int bad;

  mux_8x1_rr #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack), .dout(dout),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [7:0]  req;
    logic [31:0] din;
    logic        rdy;
    logic        v;
    logic [7:0]  ack;
    logic [2:0]  sel;
    logic [3:0]  dout;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect5(input string tag, input logic v, input logic [7:0] a, input logic [2:0] s,
                         input logic [3:0] d, input logic [7:0] c);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".ack"},       32'(ack),       32'(a));
    chk({tag, ".sel"},       32'(sel),       32'(s));
    chk({tag, ".dout"},      32'(dout),      32'(d));
    chk({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(c));
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [31:0] d, input logic rd);
    rst_n     = r;
    req       = rq;
    din       = d;
    out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lane(input logic [31:0] d, input int k);
    logic [31:0] t;
    t = d >> (4 * k);
    return t[3:0];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; req = 8'h00; din = '0; out_ready = 1'b0;

    // rst, req, din, rdy -> valid, ack, sel, dout, cnt
    tbl[0]  = '{1'b0, 8'h00, DA, 1'b0, 1'b0, 8'h00, 3'd0, 4'h0, 8'd0};
    tbl[1]  = '{1'b0, 8'hFF, DA, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0, 8'd0};
    tbl[2]  = '{1'b1, 8'h04, DA, 1'b1, 1'b1, 8'h04, 3'd2, 4'hD, 8'd0};
    tbl[3]  = '{1'b1, 8'h04, DA, 1'b1, 1'b0, 8'h00, 3'd2, 4'hD, 8'd1};
    tbl[4]  = '{1'b1, 8'h00, DA, 1'b1, 1'b0, 8'h00, 3'd2, 4'hD, 8'd1};
    tbl[5]  = '{1'b1, 8'h14, DA, 1'b0, 1'b1, 8'h10, 3'd4, 4'hB, 8'd1};
    tbl[6]  = '{1'b1, 8'h00, DB, 1'b0, 1'b1, 8'h00, 3'd4, 4'hB, 8'd1};
    tbl[7]  = '{1'b1, 8'h00, DB, 1'b1, 1'b0, 8'h00, 3'd4, 4'hB, 8'd2};
    tbl[8]  = '{1'b1, 8'h11, DA, 1'b1, 1'b1, 8'h01, 3'd0, 4'hF, 8'd2};
    tbl[9]  = '{1'b1, 8'h11, DA, 1'b1, 1'b0, 8'h00, 3'd0, 4'hF, 8'd3};
    tbl[10] = '{1'b1, 8'h11, DA, 1'b1, 1'b1, 8'h10, 3'd4, 4'hB, 8'd3};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst_n, tbl[i].req, tbl[i].din, tbl[i].rdy);
      expect5($sformatf("tbl%0d", i), tbl[i].v, tbl[i].ack, tbl[i].sel, tbl[i].dout, tbl[i].cnt);
    end

    // Fairness: all channels requesting, consumer always ready.
    step(1'b0, 8'hFF, DB, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'hFF, DB, 1'b1);
      expect5($sformatf("fair_grant%0d", i), 1'b1, 8'h01 << (i % 8), 3'(i % 8), lane(DB, i % 8), 8'(i));
      step(1'b1, 8'hFF, DB, 1'b1);
      expect5($sformatf("fair_bubble%0d", i), 1'b0, 8'h00, 3'(i % 8), lane(DB, i % 8), 8'(i + 1));
    end

    // Wrap: move ptr to 6 via a channel-5 transfer, then requests on 0 and 1.
    step(1'b0, 8'h00, DA, 1'b0);
    step(1'b1, 8'h20, DA, 1'b1);
    step(1'b1, 8'h00, DA, 1'b1);
    step(1'b1, 8'h03, DA, 1'b1);
    expect5("wrap_g0", 1'b1, 8'h01, 3'd0, 4'hF, 8'd1);
    step(1'b1, 8'h03, DA, 1'b1);
    step(1'b1, 8'h03, DA, 1'b1);
    expect5("wrap_g1", 1'b1, 8'h02, 3'd1, 4'hE, 8'd2);

    // Backpressure on channel 5 while req/din toggle.
    step(1'b0, 8'h00, DA, 1'b0);
    step(1'b1, 8'h20, DA, 1'b0);
    expect5("bp_grant", 1'b1, 8'h20, 3'd5, 4'hA, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2 == 0) ? 8'hFF : 8'h00, (i % 2 == 0) ? DB : DA, 1'b0);
      expect5($sformatf("bp_hold%0d", i), 1'b1, 8'h00, 3'd5, 4'hA, 8'd0);
    end
    step(1'b1, 8'hFF, DB, 1'b1);
    expect5("bp_done", 1'b0, 8'h00, 3'd5, 4'hA, 8'd1);

    // Reset mid-HOLD: ptr is 6 here, so a stale pointer would pick channel 7.
    step(1'b1, 8'h08, DA, 1'b0);
    expect5("rst_pend", 1'b1, 8'h08, 3'd3, 4'hC, 8'd1);
    step(1'b0, 8'h08, DA, 1'b0);
    expect5("rst_abort", 1'b0, 8'h00, 3'd0, 4'h0, 8'd0);
    step(1'b1, 8'h88, DA, 1'b0);
    expect5("rst_rescan", 1'b1, 8'h08, 3'd3, 4'hC, 8'd0);

    // Counter wrap after 256 transfers.
    step(1'b0, 8'h00, DA, 1'b0);
    for (int n = 1; n <= 256; n++) begin
      step(1'b1, 8'h01, DA, 1'b1);
      step(1'b1, 8'h01, DA, 1'b1);
      if (n == 255) chk("cnt_255", 32'(xfer_cnt), 32'd255);
      if (n == 256) chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
